fetch_unit: RTL and testbench

Instruction-fetch front end of the 5-stage RV32I pipeline. It owns the next-PC logic, drives the synchronous instruction memory, and registers the fetched instruction and its PC into the IF/ID boundary consumed by decode. It honours the hazard unit's stall with a one-entry skid buffer, so no fetched word is lost, and flushes to NOP on a taken branch or jump redirect from execute.

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end of the 5-stage RV32I pipeline. Generates the
//   next fetch PC, drives a 1-cycle synchronous instruction memory, and
//   registers the fetched word and its PC into the IF/ID boundary. A stall
//   from the hazard unit is absorbed by a one-entry skid buffer, so the word
//   already in flight is kept. A redirect from execute flushes the output to
//   NOP and restarts fetch at the target.
//
//   Optional feature macro: FETCH_PERF_EN adds the perf_fetched and
//   perf_bubbles counters and ports.
//
// Ports
//   clk          pipeline clock, all state updates on posedge
//   reset        asynchronous, active-high reset
//   stall        hazard-unit stall, freezes fetch and the IF/ID outputs
//   redirect     taken branch/jump from execute (wins over stall)
//   redirect_pc  target byte address, bits [1:0] are ignored
//   imem_addr    word-aligned fetch address (registered)
//   imem_rdata   instruction for the address presented the previous cycle
//   if_pc        PC of if_instr
//   if_instr     fetched instruction, NOP_INSTR when if_valid=0
//   if_valid     if_instr is a real fetched instruction
//   perf_fetched count of edges loading a valid instruction (FETCH_PERF_EN)
//   perf_bubbles count of unstalled edges loading a bubble (FETCH_PERF_EN)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_2000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
`ifdef FETCH_PERF_EN
  output logic        if_valid,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`else
  output logic        if_valid
`endif
);

  // BOOT: no wanted response in flight, skid empty
  // RUN : imem_rdata this cycle belongs to resp_pc, skid empty
  // HOLD: skid holds the word that arrived while stalled
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic        resp_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        skid_valid;

  logic [31:0] target_pc;
  logic        unused_bits;

  // Instruction memory is word addressed; the low address bits are dropped.
  assign target_pc   = {redirect_pc[31:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];
  assign imem_addr   = fetch_pc;

  // Next-PC, response tracking, skid buffer and IF/ID output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      fetch_pc   <= RESET_PC;
      resp_pc    <= 32'h0000_0000;
      resp_valid <= 1'b0;
      skid_pc    <= 32'h0000_0000;
      skid_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
      if_pc      <= 32'h0000_0000;
      if_instr   <= NOP_INSTR;
      if_valid   <= 1'b0;
    end else if (redirect) begin
      // Flush everything in flight, including a full skid. resp_pc also takes
      // the target so the bubble that follows never shows a stale PC.
      state      <= BOOT;
      fetch_pc   <= target_pc;
      resp_pc    <= target_pc;
      resp_valid <= 1'b0;
      skid_valid <= 1'b0;
      if_pc      <= target_pc;
      if_instr   <= NOP_INSTR;
      if_valid   <= 1'b0;
    end else if (stall) begin
      // Keep the word arriving now; the held address is re-read next cycle
      // but that copy is discarded since resp_valid drops.
      if (resp_valid && !skid_valid) begin
        skid_pc    <= resp_pc;
        skid_instr <= imem_rdata;
        skid_valid <= 1'b1;
        state      <= HOLD;
      end else begin
        skid_valid <= skid_valid;
        state      <= state;
      end
      resp_valid <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if_pc    <= skid_pc;
          if_instr <= skid_instr;
          if_valid <= 1'b1;
        end
        RUN: begin
          if_pc    <= resp_pc;
          if_instr <= imem_rdata;
          if_valid <= 1'b1;
        end
        default: begin
          if_pc    <= resp_pc;
          if_instr <= NOP_INSTR;
          if_valid <= 1'b0;
        end
      endcase
      resp_pc    <= fetch_pc;
      resp_valid <= 1'b1;
      fetch_pc   <= fetch_pc + 32'd4;
      skid_valid <= 1'b0;
      state      <= RUN;
    end
  end

`ifdef FETCH_PERF_EN
  logic loads_valid;

  // An unstalled, unredirected edge loads a real word from HOLD or RUN.
  assign loads_valid = (state == HOLD) || (state == RUN);

  // Fetch/bubble counters; stalled edges load nothing and are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_bubbles <= 32'd0;
    end else if (stall) begin
      perf_fetched <= perf_fetched;
      perf_bubbles <= perf_bubbles;
    end else if (!redirect && loads_valid) begin
      perf_fetched <= perf_fetched + 32'd1;
    end else begin
      perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int n_cmp;
  int n_err;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
`ifdef FETCH_PERF_EN
    .if_valid     (if_valid),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`else
    .if_valid     (if_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle synchronous instruction memory: word = address ^ A5A5_0000
  always @(posedge clk) imem_rdata <= imem_addr ^ 32'hA5A5_0000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a valid output word at the given PC.
  task automatic chk_word(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, mem_word(pc));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_instr"}, if_instr, 32'h0000_0013);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_bubble("rst");
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_2000);
    reset = 1'b0;

    // Free run: first edge is a bubble, then 0x2000, 0x2004
    step();
    chk_bubble("boot");
    chk("boot_addr", imem_addr, 32'h0000_2004);
    step();
    chk_word("run0", 32'h0000_2000);
    step();
    chk_word("run1", 32'h0000_2004);

    // Stall 3 cycles while 0x2008's response is in flight
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_word("stall_hold", 32'h0000_2004);
      chk("stall_addr", imem_addr, 32'h0000_200C);
    end
    stall = 1'b0;
    step();
    chk_word("rel0", 32'h0000_2008);
    step();
    chk_word("rel1", 32'h0000_200C);
    step();
    chk_word("rel2", 32'h0000_2010);

    // Plain redirect to a misaligned target
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3002;
    step();
    redirect = 1'b0;
    chk_bubble("redir0");
    chk("redir0_addr", imem_addr, 32'h0000_3000);
    step();
    chk_bubble("redir1");
    step();
    chk_word("redir2", 32'h0000_3000);
    step();
    chk_word("redir3", 32'h0000_3004);

    // Get into HOLD (skid captures 0x3008), then redirect while still stalled
    stall = 1'b1;
    step();
    chk_word("hold", 32'h0000_3004);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_4000;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk_bubble("hr0");
    chk("hr0_addr", imem_addr, 32'h0000_4000);
    chk("hr0_stale", {31'd0, if_pc != 32'h0000_3008}, 32'd1);
    step();
    chk_bubble("hr1");
    chk("hr1_stale", {31'd0, if_pc != 32'h0000_3008}, 32'd1);
    step();
    chk_word("hr2", 32'h0000_4000);
    step();
    chk_word("hr3", 32'h0000_4004);

    // Asynchronous reset between edges in the middle of a stall
    stall = 1'b1;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk_bubble("areset");
    chk("areset_addr", imem_addr, 32'h0000_2000);
    stall = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk_bubble("re_boot");
    for (int i = 0; i < 10; i++) begin
      step();
      chk_word("re_run", 32'h0000_2000 + 32'(4 * i));
    end

`ifdef FETCH_PERF_EN
    chk("perf_fetch10", perf_fetched, 32'd10);
    chk("perf_bub_boot", perf_bubbles, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5000;
    step();
    redirect = 1'b0;
    step();
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_bubbles", perf_bubbles, 32'd3);
    step();
    chk_word("perf_tgt", 32'h0000_5000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
